// File: rtl/gng_sample_fifo.sv
// gng_sample_fifo
//   Buffers Gaussian noise pairs from the GNG top and hands them to a
//   consumer one sample at a time. Each accepted pair (x0, x1) arrives in
//   sign-magnitude form. It is converted to two's complement and stored as
//   two consecutive entries. The output is first-word-fall-through.
//
// Ports
//   clk          : single clock, rising edge
//   reset        : asynchronous active-low reset
//   flush        : synchronous clear of FIFO contents (pair_count is kept)
//   pair_valid   : a noise pair is presented on x0_sm / x1_sm
//   x0_sm, x1_sm : samples in sign-magnitude form (bit 15 sign, 14:0 magnitude)
//   pair_ready   : a pair can be accepted this cycle (room for two entries)
//   sample_valid : sample_data holds the oldest stored sample
//   sample_data  : oldest sample, two's complement
//   sample_ready : consumer takes sample_data this cycle
//   level        : number of stored samples, 0..DEPTH
//   pair_count   : number of accepted pairs, wraps modulo 2^16
module gng_sample_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          pair_valid,
  input  logic [15:0]   x0_sm,
  input  logic [15:0]   x1_sm,
  output logic          pair_ready,
  output logic          sample_valid,
  output logic [15:0]   sample_data,
  input  logic          sample_ready,
  output logic [AW:0]   level,
  output logic [15:0]   pair_count
);

  localparam int DATA_W = 16;
  // A pair needs two free entries, so accept only while level <= DEPTH-2.
  localparam logic [AW:0] LVL_RDY_MAX = (AW+1)'(DEPTH - 2);

  // Sign-magnitude to two's complement. Negative zero folds onto zero, and
  // because the magnitude is 15 bits the result never reaches -32768.
  function automatic logic signed [DATA_W-1:0] sm_to_tc(input logic [DATA_W-1:0] sm);
    logic signed [DATA_W-1:0] mag;
    mag = signed'({1'b0, sm[DATA_W-2:0]});
    if (sm[DATA_W-2:0] == '0)
      return '0;
    else if (sm[DATA_W-1])
      return -mag;
    else
      return mag;
  endfunction

  logic signed [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic [AW:0]              level_nxt;
  logic                     wr_en;
  logic                     rd_en;

  // pair_ready depends only on registered level plus the reset pin, so a
  // read in the same cycle cannot open the door early.
  assign pair_ready   = reset & (level <= LVL_RDY_MAX);
  assign sample_valid = (level != '0);
  assign sample_data  = mem[rd_ptr];

  // flush discards any same-cycle write or read.
  assign wr_en = pair_valid & pair_ready & ~flush;
  assign rd_en = sample_valid & sample_ready & ~flush;

  always_comb begin
    level_nxt = level;
    unique case ({wr_en, rd_en})
      2'b10:   level_nxt = level + (AW+1)'(2);
      2'b01:   level_nxt = level - (AW+1)'(1);
      2'b11:   level_nxt = level + (AW+1)'(1);
      default: level_nxt = level;
    endcase
  end

  // Storage: data path only, no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr]           <= sm_to_tc(x0_sm);
      mem[wr_ptr + AW'(1)]  <= sm_to_tc(x1_sm);
    end
  end

  // Control state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      pair_count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr     <= wr_ptr + AW'(2);
        pair_count <= pair_count + 16'd1;
      end
      if (rd_en)
        rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt;
    end
  end

endmodule

// File: tb/tb_gng_sample_fifo.sv
// tb_gng_sample_fifo
//   Directed bench for gng_sample_fifo (DEPTH=16). Inputs are driven on the
//   falling edge and outputs are sampled on the falling edge. A small queue
//   model tracks stored samples, level and pair_count.
module tb_gng_sample_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          pair_valid;
  logic [15:0]   x0_sm;
  logic [15:0]   x1_sm;
  logic          pair_ready;
  logic          sample_valid;
  logic [15:0]   sample_data;
  logic          sample_ready;
  logic [AW:0]   level;
  logic [15:0]   pair_count;

  gng_sample_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .pair_valid   (pair_valid),
    .x0_sm        (x0_sm),
    .x1_sm        (x1_sm),
    .pair_ready   (pair_ready),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .sample_ready (sample_ready),
    .level        (level),
    .pair_count   (pair_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_q [$];
  int          mlevel = 0;
  logic [15:0] mcount = 16'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference conversion written with integer negation.
  function automatic logic [15:0] ref_conv(input logic [15:0] sm);
    int v;
    v = int'(sm[14:0]);
    if (sm[15]) v = -v;
    return v[15:0];
  endfunction

  // One clock cycle: check outputs against the model, drive inputs, advance.
  task automatic cyc(input bit push, input logic [15:0] a, input logic [15:0] b,
                     input bit pop, input bit fl, output bit acc);
    bit rd;
    chk("pair_ready", pair_ready, (mlevel <= DEPTH - 2));
    chk("sample_valid", sample_valid, (mlevel != 0));
    if (mlevel != 0) chk("sample_data", sample_data, exp_q[0]);
    acc = push && (mlevel <= DEPTH - 2) && !fl;
    rd  = pop && (mlevel != 0) && !fl;
    pair_valid   = push;
    x0_sm        = a;
    x1_sm        = b;
    sample_ready = pop;
    flush        = fl;
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (rd) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(ref_conv(a));
        exp_q.push_back(ref_conv(b));
        mcount = mcount + 16'd1;
      end
    end
    mlevel = exp_q.size();
    @(negedge clk);
    pair_valid   = 1'b0;
    sample_ready = 1'b0;
    flush        = 1'b0;
    chk("level", level, mlevel);
    chk("pair_count", pair_count, mcount);
  endtask

  initial begin
    bit acc;
    int sent;
    int guard;
    logic [15:0] ra, rb;

    reset = 1'b0; flush = 1'b0; pair_valid = 1'b0; sample_ready = 1'b0;
    x0_sm = '0; x1_sm = '0;
    repeat (2) @(negedge clk);
    chk("rst_level", level, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_ready", pair_ready, 0);
    chk("rst_count", pair_count, 0);
    reset = 1'b1;
    #1;
    chk("rel_ready", pair_ready, 1);

    // Sign conversion and first-word latency.
    cyc(1, 16'h0005, 16'h8005, 0, 0, acc);
    chk("lat_valid", sample_valid, 1);
    chk("lat_x0", sample_data, 16'h0005);
    cyc(1, 16'h8000, 16'h7FFF, 0, 0, acc);
    chk("conv_count", pair_count, 16'd2);
    chk("conv_s0", sample_data, 16'h0005);
    cyc(0, '0, '0, 1, 0, acc);
    chk("conv_s1", sample_data, 16'hFFFB);
    cyc(0, '0, '0, 1, 0, acc);
    chk("conv_s2", sample_data, 16'h0000);
    cyc(0, '0, '0, 1, 0, acc);
    chk("conv_s3", sample_data, 16'h7FFF);
    cyc(0, '0, '0, 1, 0, acc);
    chk("conv_empty", sample_valid, 0);

    // Fill with no reads, hold a 9th pair until two reads free room.
    for (int i = 0; i < 8; i++)
      cyc(1, 16'(16'h0100 + 2*i), 16'(16'h0101 + 2*i), 0, 0, acc);
    chk("full_level", level, 16);
    chk("full_ready", pair_ready, 0);
    for (int i = 0; i < 3; i++) cyc(1, 16'h8003, 16'h0004, 0, 0, acc);
    chk("held_count", pair_count, 16'd10);
    cyc(1, 16'h8003, 16'h0004, 1, 0, acc);
    chk("held_l15", level, 15);
    cyc(1, 16'h8003, 16'h0004, 1, 0, acc);
    chk("held_l14", level, 14);
    chk("held_ready", pair_ready, 1);
    cyc(1, 16'h8003, 16'h0004, 0, 0, acc);
    chk("held_acc", acc, 1);
    chk("held_level", level, 16);
    for (int i = 0; i < 16; i++) cyc(0, '0, '0, 1, 0, acc);

    // Simultaneous write and read at level 6.
    for (int i = 0; i < 3; i++)
      cyc(1, 16'(16'h8010 + i), 16'(16'h0020 + i), 0, 0, acc);
    chk("sim_l6", level, 6);
    cyc(1, 16'h1234, 16'h9234, 1, 0, acc);
    chk("sim_l7", level, 7);
    for (int i = 0; i < 7; i++) cyc(0, '0, '0, 1, 0, acc);

    // Random-ready streaming across several pointer wraps.
    sent = 0; guard = 0;
    ra = 16'($urandom); rb = 16'($urandom);
    while ((sent < 40 || mlevel != 0) && guard < 3000) begin
      cyc(sent < 40, ra, rb, bit'($urandom_range(0, 1)), 0, acc);
      if (acc) begin
        sent++;
        ra = 16'($urandom); rb = 16'($urandom);
      end
      guard++;
    end
    chk("wrap_done", (guard < 3000), 1);

    // Flush beats a same-cycle write and read at level 5.
    for (int i = 0; i < 3; i++) cyc(1, 16'(16'h0040 + i), 16'(16'h8040 + i), 0, 0, acc);
    cyc(0, '0, '0, 1, 0, acc);
    chk("fl_l5", level, 5);
    cyc(1, 16'h0777, 16'h0888, 1, 1, acc);
    chk("fl_level", level, 0);
    chk("fl_valid", sample_valid, 0);
    chk("fl_count", pair_count, mcount);

    // Asynchronous reset between edges at level 9.
    for (int i = 0; i < 5; i++) cyc(1, 16'(16'h0050 + i), 16'(16'h0060 + i), 0, 0, acc);
    cyc(0, '0, '0, 1, 0, acc);
    chk("ar_l9", level, 9);
    #2 reset = 1'b0;
    #1;
    chk("ar_level", level, 0);
    chk("ar_valid", sample_valid, 0);
    chk("ar_ready", pair_ready, 0);
    chk("ar_count", pair_count, 0);
    exp_q.delete(); mlevel = 0; mcount = 16'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    cyc(1, 16'h0001, 16'h0002, 0, 0, acc);
    chk("ar_first", sample_data, 16'h0001);
    cyc(0, '0, '0, 1, 0, acc);
    chk("ar_second", sample_data, 16'h0002);
    cyc(0, '0, '0, 1, 0, acc);
    chk("ar_empty", sample_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
